// File: rtl/jtframe_arb_pkg.sv
// Shared definitions for the SDRAM slot arbiter: FSM encoding and the
// helper that locates a slot's address field inside the packed address bus.
package jtframe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } arb_state_t;

  // Slot i owns bits [slot_lsb(i, aw) +: aw] of the packed address bus
  function automatic int slot_lsb(input int slot, input int aw);
    return slot * aw;
  endfunction

endpackage

// File: rtl/jtframe_slot_arb_if.sv
// Bundle of slot-side and SDRAM-controller-side signals around the arbiter.
// master = arbiter view, slave = the clients and controller around it.
interface jtframe_slot_arb_if #(
  parameter int SLOTS = 10,
  parameter int AW    = 22
);
  logic                vblank;
  logic                downloading;
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS-1:0]    slot_wr;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [15:0]         slot_din;
  logic [1:0]          slot_wrmask;
  logic [SLOTS-1:0]    slot_ok;
  logic [31:0]         slot_dout;
  logic                sdram_req;
  logic                sdram_ack;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_rnw;
  logic [1:0]          sdram_wrmask;
  logic [15:0]         data_write;
  logic                data_rdy;
  logic [31:0]         data_read;
  logic                refresh_en;

  modport master (
    input  vblank, downloading, slot_cs, slot_wr, slot_addr, slot_din, slot_wrmask,
           sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr, sdram_rnw, sdram_wrmask,
           data_write, refresh_en
  );

  modport slave (
    output vblank, downloading, slot_cs, slot_wr, slot_addr, slot_din, slot_wrmask,
           sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr, sdram_rnw, sdram_wrmask,
           data_write, refresh_en
  );
endinterface

// File: rtl/jtframe_arb_pick.sv
// Combinational selector: first pending slot found walking upward from
// start (wrapping at SLOTS), returned both as one-hot and as an index.
module jtframe_arb_pick #(
  parameter int SLOTS = 10,
  parameter int IW    = 4
)(
  input  logic [SLOTS-1:0] pending,
  input  logic [IW-1:0]    start,
  output logic [SLOTS-1:0] grant,
  output logic [IW-1:0]    idx
);
  logic        found;
  logic [IW:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < SLOTS; k++) begin
      pos = {1'b0, start} + (IW+1)'(k);
      if (pos >= (IW+1)'(SLOTS)) pos = pos - (IW+1)'(SLOTS);
      if (!found && pending[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_onehot
      assign grant[gi] = found && (idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/jtframe_slot_arb.sv
// Multi-slot SDRAM arbiter: grants one pending slot at a time to the
// controller and keeps a per-slot ok flag valid while cs and address hold.
module jtframe_slot_arb
  import jtframe_arb_pkg::*;
#(
  parameter int               SLOTS  = 10,
  parameter int               AW     = 22,
  parameter int               WRSLOT = 1,
  parameter int               RR     = 1,
  parameter logic [SLOTS-1:0] VBMASK = '1
)(
  input  logic                clk,
  input  logic                rst,
  jtframe_slot_arb_if.master  bus
);
  localparam int               IW       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(SLOTS-1);
  localparam logic [IW-1:0]    WR_IDX   = IW'(WRSLOT);
  localparam logic [SLOTS-1:0] WR_HOT   = SLOTS'(1) << WRSLOT;

  arb_state_t       state_reg;
  logic [IW-1:0]    last_reg, gnt_reg, start, pick_idx;
  logic [SLOTS-1:0] ok_reg, pending, pick_hot, addr_chg;
  logic [AW-1:0]    ok_addr_reg [SLOTS];
  logic [AW-1:0]    slot_addr_w [SLOTS];
  logic [AW-1:0]    addr_reg;
  logic             stale_reg, req_reg, rnw_reg, any, is_wr;
  logic [1:0]       mask_reg;
  logic [15:0]      dw_reg;
  logic [31:0]      dout_reg;

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign slot_addr_w[gi] = bus.slot_addr[slot_lsb(gi, AW) +: AW];
      assign addr_chg[gi]    = slot_addr_w[gi] != ok_addr_reg[gi];
      assign pending[gi]     = bus.slot_cs[gi] & ~ok_reg[gi] & (~bus.vblank | VBMASK[gi]);
    end
  endgenerate

  assign start = (RR != 0) ? ((last_reg == LAST_IDX) ? '0 : last_reg + 1'b1) : '0;
  assign any   = |pick_hot;
  assign is_wr = (|(bus.slot_wr & WR_HOT)) && (pick_idx == WR_IDX);

  jtframe_arb_pick #(.SLOTS(SLOTS), .IW(IW)) u_pick (
    .pending (pending),
    .start   (start),
    .grant   (pick_hot),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.downloading) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      ok_reg    <= '0;
      stale_reg <= 1'b0;
      if (rst) begin
        last_reg <= LAST_IDX;
        gnt_reg  <= '0;
        addr_reg <= '0;
        rnw_reg  <= 1'b1;
        mask_reg <= 2'b11;
        dw_reg   <= '0;
        dout_reg <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++)
        if (ok_reg[i] && (!bus.slot_cs[i] || addr_chg[i])) ok_reg[i] <= 1'b0;
      case (state_reg)
        IDLE: if (any) begin
          gnt_reg                <= pick_idx;
          last_reg               <= pick_idx;
          ok_addr_reg[pick_idx]  <= slot_addr_w[pick_idx];
          addr_reg               <= slot_addr_w[pick_idx];
          rnw_reg                <= ~is_wr;
          dw_reg                 <= bus.slot_din;
          mask_reg               <= is_wr ? bus.slot_wrmask : 2'b11;
          req_reg                <= 1'b1;
          stale_reg              <= 1'b0;
          state_reg              <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // A client that leaves or moves mid-access must not see stale data flagged ok
          if (!bus.slot_cs[gnt_reg] || addr_chg[gnt_reg]) stale_reg <= 1'b1;
          if (bus.sdram_ack) begin
            req_reg   <= 1'b0;
            state_reg <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (bus.data_rdy) begin
            if (rnw_reg) dout_reg <= bus.data_read;
            if (!stale_reg) ok_reg[gnt_reg] <= 1'b1;
            state_reg <= IDLE;
          end else if (!bus.slot_cs[gnt_reg] || addr_chg[gnt_reg]) begin
            stale_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.slot_ok      = ok_reg;
  assign bus.slot_dout    = dout_reg;
  assign bus.sdram_req    = req_reg;
  assign bus.sdram_addr   = addr_reg;
  assign bus.sdram_rnw    = rnw_reg;
  assign bus.sdram_wrmask = mask_reg;
  assign bus.data_write   = dw_reg;
  assign bus.refresh_en   = (state_reg == IDLE) & ~any & ~bus.downloading & ~rst;

endmodule

// File: tb/tb_jtframe_slot_arb.sv
// Directed bench: a round-robin instance with a vblank mask and a
// fixed-priority instance share one hand-driven controller model.
module tb_jtframe_slot_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        ack, rdy, sel;
  logic [31:0] data_read;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  jtframe_slot_arb_if #(.SLOTS(10), .AW(22)) a_if ();
  jtframe_slot_arb_if #(.SLOTS(10), .AW(22)) b_if ();

  assign a_if.sdram_ack = ack;
  assign b_if.sdram_ack = ack;
  assign a_if.data_rdy  = rdy;
  assign b_if.data_rdy  = rdy;
  assign a_if.data_read = data_read;
  assign b_if.data_read = data_read;

  jtframe_slot_arb #(.SLOTS(10), .AW(22), .WRSLOT(1), .RR(1), .VBMASK(10'h208)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if));
  jtframe_slot_arb #(.SLOTS(10), .AW(22), .WRSLOT(1), .RR(0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if));

  logic        m_req, m_ref, m_rnw;
  logic [21:0] m_addr;
  logic [9:0]  m_ok;
  logic [31:0] m_dout;
  logic [1:0]  m_mask;
  logic [15:0] m_dw;
  assign m_req  = sel ? b_if.sdram_req    : a_if.sdram_req;
  assign m_ref  = sel ? b_if.refresh_en   : a_if.refresh_en;
  assign m_rnw  = sel ? b_if.sdram_rnw    : a_if.sdram_rnw;
  assign m_addr = sel ? b_if.sdram_addr   : a_if.sdram_addr;
  assign m_ok   = sel ? b_if.slot_ok      : a_if.slot_ok;
  assign m_dout = sel ? b_if.slot_dout    : a_if.slot_dout;
  assign m_mask = sel ? b_if.sdram_wrmask : a_if.sdram_wrmask;
  assign m_dw   = sel ? b_if.data_write   : a_if.data_write;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_addr(input logic which, input int idx, input logic [21:0] v);
    if (which) b_if.slot_addr[idx*22 +: 22] = v;
    else       a_if.slot_addr[idx*22 +: 22] = v;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!m_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " req"}, 64'(m_req), 64'd1);
  endtask

  task automatic finish_txn(input string tag, input logic [3:0] idx, input logic [31:0] rd,
                            input logic exp_ok);
    chk({tag, " refresh busy"}, 64'(m_ref), 64'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk({tag, " req drop"}, 64'(m_req), 64'd0);
    chk({tag, " ok pre"}, 64'(m_ok[idx]), 64'd0);
    data_read = rd; rdy = 1'b1; tick(); rdy = 1'b0;
    chk({tag, " ok"}, 64'(m_ok[idx]), 64'(exp_ok));
  endtask

  task automatic serve(input string tag, input logic [3:0] idx, input logic [21:0] addr,
                       input logic [31:0] rd, input logic exp_ok);
    wait_req(tag);
    chk({tag, " addr"}, 64'(m_addr), 64'(addr));
    finish_txn(tag, idx, rd, exp_ok);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; rdy = 1'b0; sel = 1'b0; data_read = '0;
    a_if.vblank = 0; a_if.downloading = 0; a_if.slot_cs = '0; a_if.slot_wr = '0;
    a_if.slot_addr = '0; a_if.slot_din = '0; a_if.slot_wrmask = 2'b11;
    b_if.vblank = 0; b_if.downloading = 0; b_if.slot_cs = '0; b_if.slot_wr = '0;
    b_if.slot_addr = '0; b_if.slot_din = '0; b_if.slot_wrmask = 2'b11;
    tick(); tick();
    chk("rst req", 64'(m_req), 64'd0);
    chk("rst ok", 64'(m_ok), 64'd0);
    chk("rst dout", 64'(m_dout), 64'd0);
    chk("rst addr", 64'(m_addr), 64'd0);
    chk("rst rnw", 64'(m_rnw), 64'd1);
    chk("rst wrmask", 64'(m_mask), 64'd3);
    chk("rst data_write", 64'(m_dw), 64'd0);
    chk("rst refresh", 64'(m_ref), 64'd0);
    rst = 1'b0; tick();
    chk("idle refresh", 64'(m_ref), 64'd1);

    // Round-robin order 0, 3, 7
    set_addr(0, 0, 22'h000100); set_addr(0, 3, 22'h000300); set_addr(0, 7, 22'h000700);
    a_if.slot_cs = 10'h089;
    serve("rr0", 4'd0, 22'h000100, 32'h11110000, 1'b1);
    chk("rr0 dout", 64'(m_dout), 64'h11110000);
    serve("rr3", 4'd3, 22'h000300, 32'h33330000, 1'b1);
    serve("rr7", 4'd7, 22'h000700, 32'h77770000, 1'b1);
    chk("rr7 dout", 64'(m_dout), 64'h77770000);
    chk("rr all ok refresh", 64'(m_ref), 64'd1);
    a_if.slot_cs = '0; tick();
    chk("rr cs drop ok", 64'(m_ok), 64'd0);

    // Write through the write-capable slot
    set_addr(0, 1, 22'h3A8010);
    a_if.slot_wr = 10'h002; a_if.slot_din = 16'hBEEF; a_if.slot_wrmask = 2'b01;
    a_if.slot_cs = 10'h002;
    wait_req("wr");
    chk("wr addr", 64'(m_addr), 64'h3A8010);
    chk("wr rnw", 64'(m_rnw), 64'd0);
    chk("wr data", 64'(m_dw), 64'hBEEF);
    chk("wr mask", 64'(m_mask), 64'd1);
    finish_txn("wr", 4'd1, 32'hDEADDEAD, 1'b1);
    chk("wr dout kept", 64'(m_dout), 64'h77770000);
    a_if.slot_cs = '0; a_if.slot_wr = '0; tick();

    // vblank masks slot 2; slot 9 allowed
    a_if.vblank = 1'b1;
    set_addr(0, 2, 22'h000200); set_addr(0, 9, 22'h000900);
    a_if.slot_cs = 10'h204;
    serve("vb9", 4'd9, 22'h000900, 32'h99990000, 1'b1);
    tick(); tick();
    chk("vb masked req", 64'(m_req), 64'd0);
    chk("vb masked refresh", 64'(m_ref), 64'd1);
    a_if.vblank = 1'b0;
    serve("vb2", 4'd2, 22'h000200, 32'h22220000, 1'b1);
    a_if.slot_cs = '0; tick();

    // Write flag on a read-only slot is ignored
    set_addr(0, 6, 22'h000600);
    a_if.slot_wr = '1; a_if.slot_cs = 10'h040;
    wait_req("rd6");
    chk("rd6 rnw", 64'(m_rnw), 64'd1);
    chk("rd6 mask", 64'(m_mask), 64'd3);
    finish_txn("rd6", 4'd6, 32'h66660000, 1'b1);
    chk("rd6 dout", 64'(m_dout), 64'h66660000);
    a_if.slot_cs = '0; a_if.slot_wr = '0; tick();

    // Address change while ok clears ok and triggers a new access
    set_addr(0, 4, 22'h040000); a_if.slot_cs = 10'h010;
    serve("ad4", 4'd4, 22'h040000, 32'h44440000, 1'b1);
    set_addr(0, 4, 22'h040004); tick();
    chk("ad4 ok clear", 64'(m_ok[4]), 64'd0);
    serve("ad4b", 4'd4, 22'h040004, 32'h44440004, 1'b1);
    chk("ad4b dout", 64'(m_dout), 64'h44440004);
    a_if.slot_cs = '0; tick();

    // cs dropped mid-transaction: completes but no ok
    set_addr(0, 8, 22'h000800); a_if.slot_cs = 10'h100;
    wait_req("cs8");
    chk("cs8 addr", 64'(m_addr), 64'h000800);
    a_if.slot_cs = '0;
    finish_txn("cs8", 4'd8, 32'h88880000, 1'b0);
    chk("cs8 dout", 64'(m_dout), 64'h88880000);

    // Fixed priority: slot 2 twice before slot 5
    sel = 1'b1;
    set_addr(1, 2, 22'h000200); set_addr(1, 5, 22'h000500);
    b_if.slot_cs = 10'h024;
    wait_req("fp2a");
    chk("fp2a addr", 64'(m_addr), 64'h000200);
    set_addr(1, 2, 22'h000204);
    finish_txn("fp2a", 4'd2, 32'h0000000A, 1'b0);
    serve("fp2b", 4'd2, 22'h000204, 32'h0000000B, 1'b1);
    serve("fp5", 4'd5, 22'h000500, 32'h0000000C, 1'b1);
    chk("fp5 dout", 64'(m_dout), 64'h0000000C);
    b_if.slot_cs = '0; tick();
    sel = 1'b0;

    // downloading aborts an access in WAIT_RDY
    a_if.slot_cs = 10'h001;
    serve("dl0", 4'd0, 22'h000100, 32'h0A0A0A0A, 1'b1);
    set_addr(0, 5, 22'h000500); a_if.slot_cs = 10'h021;
    wait_req("dl5");
    chk("dl5 addr", 64'(m_addr), 64'h000500);
    ack = 1'b1; tick(); ack = 1'b0;
    a_if.downloading = 1'b1; tick();
    chk("dl req", 64'(m_req), 64'd0);
    chk("dl ok", 64'(m_ok), 64'd0);
    chk("dl refresh", 64'(m_ref), 64'd0);
    data_read = 32'h00000BAD; rdy = 1'b1; tick(); rdy = 1'b0;
    chk("dl late rdy ok", 64'(m_ok), 64'd0);
    chk("dl late rdy dout", 64'(m_dout), 64'h0A0A0A0A);
    a_if.slot_cs = '0; a_if.downloading = 1'b0; tick();

    // Reset mid-transaction abandons the access
    a_if.slot_cs = 10'h040;
    wait_req("rs6");
    chk("rs6 addr", 64'(m_addr), 64'h000600);
    rst = 1'b1; tick();
    chk("rs req", 64'(m_req), 64'd0);
    rst = 1'b0; a_if.slot_cs = '0;
    data_read = 32'hFFFFFFFF; rdy = 1'b1; tick(); rdy = 1'b0;
    chk("rs late ok", 64'(m_ok), 64'd0);
    chk("rs late dout", 64'(m_dout), 64'd0);
    chk("rs refresh", 64'(m_ref), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
